// File: rtl/mem_layout_pkg.sv
// Shared constants and types for the PWL generator memory/sequencing slice.
package mem_layout_pkg;

  localparam int unsigned PWL_MAX_LINES = 600;
  localparam int unsigned PWL_LINE_W    = 48;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ARM     = 3'd2,
    ST_RUNNING = 3'd3,
    ST_HALT    = 3'd4
  } pwl_ctrl_state_t;

endpackage

// File: rtl/pwl_watchdog.sv
// Idle-cycle watchdog: counts enabled cycles, flags the TIMEOUT_CYCLES-th one.
module pwl_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter clears on request, otherwise advances while enabled and holds at the limit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Expiry is seen in the cycle that would be the TIMEOUT_CYCLES-th idle cycle.
  assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/pwl_run_ctrl.sv
// Sequencer: loads N PWL lines into pwl_generator, then issues run/halt.
module pwl_run_ctrl
  import mem_layout_pkg::*;
#(
  parameter int unsigned DMA_DATA_WIDTH = PWL_LINE_W,
  parameter int unsigned MAX_LINES      = PWL_MAX_LINES,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               cfg_start,
  input  logic [$clog2(MAX_LINES+1)-1:0]     cfg_num_lines,
  input  logic                               cfg_abort,
  input  logic [DMA_DATA_WIDTH-1:0]          src_data,
  input  logic                               src_valid,
  output logic                               src_ready,
  output logic [DMA_DATA_WIDTH-1:0]          pwl_data,
  output logic                               pwl_valid,
  output logic                               pwl_last,
  input  logic                               pwl_ready,
  input  logic                               pwl_rdy_to_run,
  output logic                               pwl_run,
  output logic                               pwl_halt,
  output logic                               busy,
  output logic                               error,
  output logic [$clog2(MAX_LINES+1)-1:0]     lines_sent
);

  localparam int unsigned CW = $clog2(MAX_LINES + 1);

  pwl_ctrl_state_t state_q, state_d;
  logic [CW-1:0]   n_lines_q, n_lines_d;
  logic [CW-1:0]   lines_sent_q, lines_sent_d;
  logic            error_q, error_d;
  logic            run_q, halt_q, busy_q;

  logic            in_load_c;
  logic            xfer_c;
  logic            last_beat_c;
  logic            start_ok_c;
  logic            wd_en_c;
  logic            wd_clear_c;
  logic            wd_expired;

  assign in_load_c   = (state_q == ST_LOAD);
  assign xfer_c      = in_load_c && src_valid && pwl_ready;
  assign last_beat_c = (lines_sent_q == (n_lines_q - CW'(1)));
  assign start_ok_c  = (cfg_num_lines != '0) && (cfg_num_lines <= CW'(MAX_LINES));

  // Stream is a straight passthrough during LOAD and fully quiet otherwise.
  assign src_ready = in_load_c && pwl_ready;
  assign pwl_valid = in_load_c && src_valid;
  assign pwl_data  = in_load_c ? src_data : '0;
  assign pwl_last  = pwl_valid && last_beat_c;

  assign pwl_run    = run_q;
  assign pwl_halt   = halt_q;
  assign busy       = busy_q;
  assign error      = error_q;
  assign lines_sent = lines_sent_q;

  // Watchdog runs on stalled LOAD cycles and every ARM cycle; any transfer or state change restarts it.
  assign wd_en_c    = (in_load_c && !xfer_c) || (state_q == ST_ARM);
  assign wd_clear_c = xfer_c || (state_d != state_q) ||
                      !((state_q == ST_LOAD) || (state_q == ST_ARM));

  pwl_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (wd_clear_c),
    .en      (wd_en_c),
    .expired (wd_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, load bookkeeping and error flag; abort beats completion, completion beats timeout.
  always_comb begin
    state_d      = state_q;
    n_lines_d    = n_lines_q;
    lines_sent_d = lines_sent_q;
    error_d      = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (start_ok_c) begin
            n_lines_d    = cfg_num_lines;
            lines_sent_d = '0;
            error_d      = 1'b0;
            state_d      = ST_LOAD;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (xfer_c && (lines_sent_q != n_lines_q)) begin
          lines_sent_d = lines_sent_q + CW'(1);
        end
        if (cfg_abort) begin
          state_d = ST_HALT;
        end else if (xfer_c && last_beat_c) begin
          state_d = ST_ARM;
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_ARM: begin
        if (cfg_abort) begin
          state_d = ST_HALT;
        end else if (pwl_rdy_to_run) begin
          state_d = ST_RUNNING;
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = ST_HALT;
        end
      end
      ST_RUNNING: begin
        if (cfg_abort) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered control outputs and load bookkeeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_lines_q    <= '0;
      lines_sent_q <= '0;
      error_q      <= 1'b0;
      run_q        <= 1'b0;
      halt_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      n_lines_q    <= n_lines_d;
      lines_sent_q <= lines_sent_d;
      error_q      <= error_d;
      run_q        <= (state_q == ST_ARM) && (state_d == ST_RUNNING);
      halt_q       <= (state_d == ST_HALT);
      busy_q       <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_pwl_run_ctrl.sv
// Self-checking bench for pwl_run_ctrl: vector table, directed corner cases, random vs. reference model.
module tb_pwl_run_ctrl;

  localparam int unsigned DW = 48;
  localparam int unsigned ML = 600;
  localparam int unsigned TO = 1024;
  localparam int unsigned CW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_start, cfg_abort;
  logic [CW-1:0] cfg_num_lines;
  logic [DW-1:0] src_data;
  logic          src_valid, src_ready;
  logic [DW-1:0] pwl_data;
  logic          pwl_valid, pwl_last, pwl_ready;
  logic          pwl_rdy_to_run, pwl_run, pwl_halt, busy, error;
  logic [CW-1:0] lines_sent;

  always #5 clk = ~clk;

  pwl_run_ctrl #(
    .DMA_DATA_WIDTH(DW),
    .MAX_LINES     (ML),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cfg_start     (cfg_start),
    .cfg_num_lines (cfg_num_lines),
    .cfg_abort     (cfg_abort),
    .src_data      (src_data),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .pwl_data      (pwl_data),
    .pwl_valid     (pwl_valid),
    .pwl_last      (pwl_last),
    .pwl_ready     (pwl_ready),
    .pwl_rdy_to_run(pwl_rdy_to_run),
    .pwl_run       (pwl_run),
    .pwl_halt      (pwl_halt),
    .busy          (busy),
    .error         (error),
    .lines_sent    (lines_sent)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;
  int runs     = 0;
  int halts    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of the load/run cycle as described by the block's rules.
  localparam int P_IDLE = 0, P_LOAD = 1, P_ARM = 2, P_RUN = 3, P_HALT = 4;
  int m_ph, m_n, m_sent, m_idle;
  bit m_err, m_run;

  task automatic model_reset();
    m_ph = P_IDLE; m_n = 0; m_sent = 0; m_idle = 0; m_err = 0; m_run = 0;
  endtask

  task automatic go(input int ph);
    m_ph   = ph;
    m_idle = 0;
  endtask

  task automatic model_update();
    bit xfer;
    bit nrun;
    nrun = 0;
    if (!rstn) begin
      model_reset();
    end else begin
      xfer = (m_ph == P_LOAD) && src_valid && pwl_ready;
      case (m_ph)
        P_IDLE: if (cfg_start) begin
          if (int'(cfg_num_lines) >= 1 && int'(cfg_num_lines) <= int'(ML)) begin
            m_n = int'(cfg_num_lines); m_sent = 0; m_err = 0; go(P_LOAD);
          end else m_err = 1;
        end
        P_LOAD: begin
          if (xfer) begin
            m_sent = (m_sent + 1 > m_n) ? m_n : m_sent + 1;
            m_idle = 0;
          end else m_idle++;
          if (cfg_abort) go(P_HALT);
          else if (xfer && m_sent == m_n) go(P_ARM);
          else if (m_idle >= int'(TO)) begin m_err = 1; go(P_HALT); end
        end
        P_ARM: begin
          m_idle++;
          if (cfg_abort) go(P_HALT);
          else if (pwl_rdy_to_run) begin go(P_RUN); nrun = 1; end
          else if (m_idle >= int'(TO)) begin m_err = 1; go(P_HALT); end
        end
        P_RUN:  if (cfg_abort) go(P_HALT);
        default: go(P_IDLE);
      endcase
    end
    m_run = nrun;
  endtask

  task automatic cmp_model();
    bit ld;
    ld = (m_ph == P_LOAD);
    chk("src_ready",  64'(src_ready),  64'(ld && pwl_ready));
    chk("pwl_valid",  64'(pwl_valid),  64'(ld && src_valid));
    chk("pwl_last",   64'(pwl_last),   64'(ld && src_valid && (m_sent == m_n - 1)));
    chk("pwl_data",   64'(pwl_data),   ld ? 64'(src_data) : 64'd0);
    chk("pwl_run",    64'(pwl_run),    64'(m_run));
    chk("pwl_halt",   64'(pwl_halt),   64'(m_ph == P_HALT));
    chk("busy",       64'(busy),       64'(m_ph != P_IDLE));
    chk("error",      64'(error),      64'(m_err));
    chk("lines_sent", 64'(lines_sent), 64'(m_sent));
    if (pwl_valid && pwl_ready) beats++;
    if (pwl_run) runs++;
    if (pwl_halt) halts++;
  endtask

  typedef struct {
    logic          start;
    logic [CW-1:0] num;
    logic          abort;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          rdy;
    logic          e_src_ready, e_valid, e_last;
    logic [DW-1:0] e_data;
    logic          e_run, e_halt, e_busy, e_err;
    logic [CW-1:0] e_sent;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [CW-1:0] n, input logic a, input logic v,
                              input logic [DW-1:0] d, input logic r, input logic rr,
                              input logic esr, input logic ev, input logic el, input logic [DW-1:0] ed,
                              input logic erun, input logic ehalt, input logic ebusy, input logic eerr,
                              input logic [CW-1:0] esent);
    vec_t t;
    t.start = s; t.num = n; t.abort = a; t.valid = v; t.data = d; t.ready = r; t.rdy = rr;
    t.e_src_ready = esr; t.e_valid = ev; t.e_last = el; t.e_data = ed;
    t.e_run = erun; t.e_halt = ehalt; t.e_busy = ebusy; t.e_err = eerr; t.e_sent = esent;
    return t;
  endfunction

  task automatic clear_in();
    cfg_start = 0; cfg_num_lines = '0; cfg_abort = 0; src_valid = 0; src_data = '0;
    pwl_ready = 0; pwl_rdy_to_run = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    cmp_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step_tbl(input vec_t t);
    cfg_start = t.start; cfg_num_lines = t.num; cfg_abort = t.abort; src_valid = t.valid;
    src_data = t.data; pwl_ready = t.ready; pwl_rdy_to_run = t.rdy;
    @(negedge clk);
    cmp_model();
    chk("tbl_src_ready",  64'(src_ready),  64'(t.e_src_ready));
    chk("tbl_pwl_valid",  64'(pwl_valid),  64'(t.e_valid));
    chk("tbl_pwl_last",   64'(pwl_last),   64'(t.e_last));
    chk("tbl_pwl_data",   64'(pwl_data),   64'(t.e_data));
    chk("tbl_pwl_run",    64'(pwl_run),    64'(t.e_run));
    chk("tbl_pwl_halt",   64'(pwl_halt),   64'(t.e_halt));
    chk("tbl_busy",       64'(busy),       64'(t.e_busy));
    chk("tbl_error",      64'(error),      64'(t.e_err));
    chk("tbl_lines_sent", 64'(lines_sent), 64'(t.e_sent));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic start_load(input int n);
    clear_in();
    cfg_start = 1; cfg_num_lines = CW'(n);
    step();
    clear_in();
  endtask

  task automatic send_beats(input int k);
    for (int i = 0; i < k; i++) begin
      src_valid = 1; pwl_ready = 1; src_data = {16'($urandom), $urandom};
      step();
    end
    clear_in();
  endtask

  vec_t tbl[14];
  int   halt_at;
  int   rsel;

  initial begin
    tbl[0]  = mk(1, 6, 0, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 48'd131169,       1, 0, 1, 1, 0, 48'd131169,       0, 0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 48'd412316991508, 1, 0, 1, 1, 0, 48'd412316991508, 0, 0, 1, 0, 1);
    tbl[3]  = mk(0, 0, 0, 1, 48'd498216271884, 1, 0, 1, 1, 0, 48'd498216271884, 0, 0, 1, 0, 2);
    tbl[4]  = mk(0, 0, 0, 1, 48'd528280912097, 1, 0, 1, 1, 0, 48'd528280912097, 0, 0, 1, 0, 3);
    tbl[5]  = mk(0, 0, 0, 1, 48'd47244509194,  1, 0, 1, 1, 0, 48'd47244509194,  0, 0, 1, 0, 4);
    tbl[6]  = mk(0, 0, 0, 1, 48'd22,           1, 0, 1, 1, 1, 48'd22,           0, 0, 1, 0, 5);
    tbl[7]  = mk(0, 0, 0, 0, 48'd0,            1, 0, 0, 0, 0, 48'd0,            0, 0, 1, 0, 6);
    tbl[8]  = mk(0, 0, 0, 0, 48'd0,            1, 1, 0, 0, 0, 48'd0,            0, 0, 1, 0, 6);
    tbl[9]  = mk(0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            1, 0, 1, 0, 6);
    tbl[10] = mk(0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            0, 0, 1, 0, 6);
    tbl[11] = mk(0, 0, 1, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            0, 0, 1, 0, 6);
    tbl[12] = mk(0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            0, 1, 1, 0, 6);
    tbl[13] = mk(0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 0, 48'd0,            0, 0, 0, 0, 6);

    // Reset state.
    rstn = 0;
    clear_in();
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_src_ready", 64'(src_ready), 64'd0);
    chk("rst_pwl_valid", 64'(pwl_valid), 64'd0);
    chk("rst_pwl_data",  64'(pwl_data),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_error",     64'(error),     64'd0);
    chk("rst_lines",     64'(lines_sent), 64'd0);
    step();
    rstn = 1;

    // Nominal load, run, abort.
    for (int i = 0; i < 14; i++) step_tbl(tbl[i]);
    clear_in();

    // Backpressure: ready toggles every cycle, valid held high.
    start_load(6);
    beats = 0;
    for (int k = 0; k < 12; k++) begin
      src_valid = 1; src_data = {16'($urandom), $urandom}; pwl_ready = (k % 2 == 0);
      step();
    end
    clear_in();
    chk("bp_beats", 64'(beats), 64'd6);
    chk("bp_lines_sent", 64'(lines_sent), 64'd6);
    chk("bp_busy", 64'(busy), 64'd1);
    cfg_abort = 1; step(); clear_in(); step(); step();

    // Invalid counts, then a valid start clears the error.
    start_load(0);
    chk("inv0_error", 64'(error), 64'd1);
    chk("inv0_busy",  64'(busy),  64'd0);
    start_load(601);
    chk("inv601_error", 64'(error), 64'd1);
    chk("inv601_busy",  64'(busy),  64'd0);
    start_load(3);
    chk("valid_clears_error", 64'(error), 64'd0);
    chk("valid_busy", 64'(busy), 64'd1);
    send_beats(3);
    pwl_rdy_to_run = 1; step(); clear_in();
    chk("n3_run", 64'(pwl_run), 64'd1);
    step(); cfg_abort = 1; step(); clear_in(); step(); step();

    // Timeout after two beats then a stalled source.
    start_load(6);
    send_beats(2);
    halt_at = -1; halts = 0;
    pwl_ready = 1;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (pwl_halt && halt_at < 0) halt_at = i;
    end
    clear_in();
    chk("to_halt_cycle", 64'(halt_at), 64'd1023);
    chk("to_halt_count", 64'(halts), 64'd1);
    chk("to_error", 64'(error), 64'd1);
    chk("to_busy", 64'(busy), 64'd0);

    // Abort while RUNNING; a start during RUNNING is ignored.
    start_load(1);
    send_beats(1);
    pwl_rdy_to_run = 1; step(); clear_in();
    chk("run_pulse", 64'(pwl_run), 64'd1);
    step();
    cfg_start = 1; cfg_num_lines = CW'(3); step(); clear_in(); step();
    chk("run_start_ignored_lines", 64'(lines_sent), 64'd1);
    chk("run_start_ignored_busy", 64'(busy), 64'd1);
    cfg_abort = 1; step(); clear_in();
    chk("run_abort_halt", 64'(pwl_halt), 64'd1);
    step();
    chk("run_abort_halt_end", 64'(pwl_halt), 64'd0);
    chk("run_abort_idle", 64'(busy), 64'd0);

    // Abort on the final beat: the beat lands, no run is issued.
    start_load(6);
    send_beats(5);
    runs = 0;
    src_valid = 1; pwl_ready = 1; src_data = 48'd22; cfg_abort = 1; pwl_rdy_to_run = 1;
    step(); clear_in();
    chk("race_lines_sent", 64'(lines_sent), 64'd6);
    chk("race_halt", 64'(pwl_halt), 64'd1);
    step(); step();
    chk("race_no_run", 64'(runs), 64'd0);

    // Reset mid-LOAD drops the stream at once, including a pending last.
    start_load(3);
    send_beats(2);
    src_valid = 1; pwl_ready = 1; src_data = 48'hABCDEF012345;
    #2;
    chk("mid_pre_last", 64'(pwl_last), 64'd1);
    rstn = 0;
    model_reset();
    #1;
    chk("mid_rst_valid", 64'(pwl_valid), 64'd0);
    chk("mid_rst_last",  64'(pwl_last),  64'd0);
    chk("mid_rst_ready", 64'(src_ready), 64'd0);
    chk("mid_rst_data",  64'(pwl_data),  64'd0);
    chk("mid_rst_busy",  64'(busy),      64'd0);
    chk("mid_rst_lines", 64'(lines_sent), 64'd0);
    step();
    clear_in();
    rstn = 1;
    step();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 4000; c++) begin
      cfg_start = ($urandom_range(0, 7) == 0);
      rsel = int'($urandom_range(0, 19));
      if (rsel == 0)      cfg_num_lines = '0;
      else if (rsel == 1) cfg_num_lines = CW'(601 + $urandom_range(0, 50));
      else                cfg_num_lines = CW'($urandom_range(1, 12));
      cfg_abort      = ($urandom_range(0, 79) == 0);
      src_valid      = ($urandom_range(0, 3) != 0);
      src_data       = {16'($urandom), $urandom};
      pwl_ready      = ($urandom_range(0, 3) != 0);
      pwl_rdy_to_run = ($urandom_range(0, 3) == 0);
      step();
    end
    clear_in();
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
